// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
// The ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, a, b, bin,
    input  busy, done, d, bout
`ifdef SERIAL_SUB_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, d, bout
`ifdef SERIAL_SUB_OVF_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor d = a - b - bin, LSB first, through one full-subtractor cell.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                rst_n,
  serial_subtractor_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] aShift_q, aShift_d;
  logic [WIDTH-1:0] bShift_q, bShift_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic a0, b0, diffBit, borrowNext;

  assign a0         = aShift_q[0];
  assign b0         = bShift_q[0];
  assign diffBit    = a0 ^ b0 ^ borrow_q;
  assign borrowNext = (~a0 & b0) | (~(a0 ^ b0) & borrow_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // DONE accepts start exactly like IDLE, which gives back-to-back operation.
  always_comb begin
    state_d  = state_q;
    aShift_d = aShift_q;
    bShift_d = bShift_q;
    borrow_d = borrow_q;
    count_d  = count_q;
    result_d = result_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          aShift_d = bus.a;
          bShift_d = bus.b;
          borrow_d = bus.bin;
          count_d  = '0;
          result_d = '0;
          busy_d   = 1'b1;
          state_d  = SHIFT;
        end else begin
          state_d  = IDLE;
        end
      end
      SHIFT: begin
        aShift_d = aShift_q >> 1;
        bShift_d = bShift_q >> 1;
        borrow_d = borrowNext;
        result_d = {diffBit, result_q[WIDTH-1:1]};
        count_d  = count_q + CW'(1);
        busy_d   = 1'b1;
        if (count_q == LAST) begin
          diff_d  = {diffBit, result_q[WIDTH-1:1]};
          bout_d  = borrowNext;
`ifdef SERIAL_SUB_OVF_EN
          // borrow_q is the borrow into the MSB while the MSB is processed.
          ovf_d   = borrow_q ^ borrowNext;
`endif
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aShift_q <= '0;
      bShift_q <= '0;
      borrow_q <= 1'b0;
      count_q  <= '0;
      result_q <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      aShift_q <= aShift_d;
      bShift_q <= bShift_d;
      borrow_q <= borrow_d;
      count_q  <= count_d;
      result_q <= result_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.d    = diff_q;
  assign bus.bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: stimulus pushes expected results, a monitor pops on done.
// Checks ovf as well when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] d;
    logic         bout;
    logic         ovf;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   testsRun    = 0;
  int   testsFailed = 0;
  int   cycleCnt    = 0;
  exp_t sb[$];
  exp_t monExp;
  exp_t lastExp;
  logic [W-1:0] va, vb;
  logic         vbin;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Independent reference: plain integer arithmetic, signed range test for overflow.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    exp_t e;
    int   ua, ub, sa, sb2, ud, sd;
    ua  = a;
    ub  = b;
    sa  = $signed(a);
    sb2 = $signed(b);
    ud  = ua - ub - int'(bin);
    sd  = sa - sb2 - int'(bin);
    e.d    = W'(ud);
    e.bout = (ud < 0);
    e.ovf  = (sd > 127) || (sd < -128);
    e.cyc  = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpected done: got done=1, expected no pending result");
      end else begin
        monExp = sb.pop_front();
        checkOutput("d", 32'(bus.d), 32'(monExp.d));
        checkOutput("bout", 32'(bus.bout), 32'(monExp.bout));
`ifdef SERIAL_SUB_OVF_EN
        checkOutput("ovf", 32'(bus.ovf), 32'(monExp.ovf));
`endif
        checkOutput("done cycle", cycleCnt, monExp.cyc);
      end
    end
  end

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                               input logic [W-1:0] expD, input logic expBout, input logic expOvf,
                               input bit track);
    exp_t e;
    bus.a     = a;
    bus.b     = b;
    bus.bin   = bin;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    if (track) begin
      e.d    = expD;
      e.bout = expBout;
      e.ovf  = expOvf;
      e.cyc  = cycleCnt + W;
      sb.push_back(e);
    end
    bus.start = 1'b0;
    bus.a     = ~a;
    bus.b     = ~b;
    bus.bin   = ~bin;
    checkOutput("busy after accept", 32'(bus.busy), 32'd1);
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 4 * W + 10) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, " pending results"}, sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bin   = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset busy", 32'(bus.busy), 32'd0);
    checkOutput("reset done", 32'(bus.done), 32'd0);
    checkOutput("reset d", 32'(bus.d), 32'd0);
    checkOutput("reset bout", 32'(bus.bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    checkOutput("reset ovf", 32'(bus.ovf), 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(8'd100, 8'd37, 1'b0, 8'd63, 1'b0, 1'b0, 1'b1);
    waitDrain("100-37");
    @(negedge clk);
    checkOutput("busy idle", 32'(bus.busy), 32'd0);
    checkOutput("done width", 32'(bus.done), 32'd0);
    checkOutput("d held idle", 32'(bus.d), 32'd63);

    applyStimulus(8'd5, 8'd9, 1'b0, 8'hFC, 1'b1, 1'b0, 1'b1);
    waitDrain("5-9");
    applyStimulus(8'd0, 8'd0, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1);
    waitDrain("0-0-1");
    applyStimulus(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b1);
    waitDrain("80-01");
    applyStimulus(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b1);
    waitDrain("10-01");

    // start held high with operands changing every cycle: only every W+1th edge accepts
    bus.start = 1'b1;
    for (int i = 0; i < 3 * (W + 1); i++) begin
      va   = W'(i * 37 + 11);
      vb   = W'(i * 53 + 3);
      vbin = i[0];
      bus.a   = va;
      bus.b   = vb;
      bus.bin = vbin;
      @(posedge clk);
      #1;
      if (i % (W + 1) == 0) begin
        lastExp     = model(va, vb, vbin);
        lastExp.cyc = cycleCnt + W;
        sb.push_back(lastExp);
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    waitDrain("back-to-back");

    applyStimulus(8'h3C, 8'h0F, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("d held mid-op", 32'(bus.d), 32'(lastExp.d));
    checkOutput("bout held mid-op", 32'(bus.bout), 32'(lastExp.bout));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid-op reset busy", 32'(bus.busy), 32'd0);
    checkOutput("mid-op reset done", 32'(bus.done), 32'd0);
    checkOutput("mid-op reset d", 32'(bus.d), 32'd0);
    checkOutput("mid-op reset bout", 32'(bus.bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    checkOutput("mid-op reset ovf", 32'(bus.ovf), 32'd0);
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 2) @(negedge clk);
    checkOutput("no done after reset", 32'(bus.done), 32'd0);

    applyStimulus(8'hAA, 8'h55, 1'b0, 8'h55, 1'b0, 1'b1, 1'b1);
    waitDrain("AA-55");
    repeat (12) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
